// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path (uart_rx and its sampler).
package uart_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int PRESCALE_W = 6;

   localparam logic [PRESCALE_W-1:0] PRESCALE_8  = PRESCALE_W'(8);
   localparam logic [PRESCALE_W-1:0] PRESCALE_16 = PRESCALE_W'(16);
   localparam logic [PRESCALE_W-1:0] PRESCALE_32 = PRESCALE_W'(32);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

   // Any ratio other than 8/16/32 falls back to 8.
   function automatic logic [PRESCALE_W-1:0] legal_prescale(input logic [PRESCALE_W-1:0] p);
      case (p)
         PRESCALE_8, PRESCALE_16, PRESCALE_32: return p;
         default:                              return PRESCALE_8;
      endcase
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-period counter and mid-bit sampler for uart_rx. Define UART_RX_MAJORITY_EN for a
// 2-of-3 vote at P/2-1, P/2, P/2+1; otherwise a single sample is taken at P/2.
module uart_rx_sampler #(
   parameter int PRESCALE_W = uart_pkg::PRESCALE_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx_in,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  start,
   input  logic                  active,
   output logic                  sampled_bit,
   output logic                  bit_done
);
   import uart_pkg::*;

   logic [PRESCALE_W-1:0] edge_cnt;
   logic [PRESCALE_W-1:0] half;
   logic [PRESCALE_W-1:0] last;

   assign half     = prescale >> 1;
   assign last     = prescale - PRESCALE_W'(1);
   assign bit_done = active && (edge_cnt == last);

   // The start-detection cycle is count 0, so the first START cycle already sits at 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         edge_cnt <= '0;
      else if (start)
         edge_cnt <= PRESCALE_W'(1);
      else if (!active || bit_done)
         edge_cnt <= '0;
      else
         edge_cnt <= edge_cnt + PRESCALE_W'(1);
   end

`ifdef UART_RX_MAJORITY_EN
   logic [2:0] samp_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         samp_r <= 3'b111;
      end else if (active) begin
         if (edge_cnt == half - PRESCALE_W'(1)) samp_r[0] <= rx_in;
         if (edge_cnt == half)                  samp_r[1] <= rx_in;
         if (edge_cnt == half + PRESCALE_W'(1)) samp_r[2] <= rx_in;
      end
   end

   assign sampled_bit = (samp_r[0] & samp_r[1]) | (samp_r[0] & samp_r[2]) | (samp_r[1] & samp_r[2]);
`else
   logic samp_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         samp_r <= 1'b1;
      else if (active && (edge_cnt == half))
         samp_r <= rx_in;
   end

   assign sampled_bit = samp_r;
`endif

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, DATA_WIDTH data bits LSB first, optional parity, one stop.
// Sampling mode selected by UART_RX_MAJORITY_EN (see uart_rx_sampler).
module uart_rx #(
   parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH,
   parameter int PRESCALE_W = uart_pkg::PRESCALE_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  RX_IN,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);
   import uart_pkg::*;

   localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);

   rx_state_e               state_r, state_nx;
   logic [PRESCALE_W-1:0]   p_lat;
   logic                    par_en_lat, par_typ_lat;
   logic [BIT_CNT_W-1:0]    bit_cnt_r;
   logic [DATA_WIDTH-1:0]   shift_r;
   logic                    par_bad_r;
   logic                    start_det, sampled_bit, bit_done, frame_ok;

   assign start_det = (state_r == IDLE) && !RX_IN;
   assign frame_ok  = sampled_bit && !par_bad_r;

   uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_in      (RX_IN),
      .prescale   (p_lat),
      .start      (start_det),
      .active     (state_r != IDLE),
      .sampled_bit(sampled_bit),
      .bit_done   (bit_done)
   );

   // NOTE: non-blocking (<=) for every flop so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= IDLE;
      else        state_r <= state_nx;
   end

   // NOTE: state_nx gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nx = state_r;
      unique case (state_r)
         IDLE:    if (!RX_IN) state_nx = START;
         START:   if (bit_done) state_nx = sampled_bit ? IDLE : DATA;
         DATA:    if (bit_done && (bit_cnt_r == BIT_CNT_W'(DATA_WIDTH - 1)))
                     state_nx = par_en_lat ? PARITY : STOP;
         PARITY:  if (bit_done) state_nx = STOP;
         STOP:    if (bit_done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_lat       <= PRESCALE_8;
         par_en_lat  <= 1'b0;
         par_typ_lat <= 1'b0;
         bit_cnt_r   <= '0;
         shift_r     <= '0;
         par_bad_r   <= 1'b0;
         P_DATA      <= '0;
         data_valid  <= 1'b0;
         par_err     <= 1'b0;
         stp_err     <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
         if (start_det) begin
            p_lat       <= legal_prescale(prescale);
            par_en_lat  <= PAR_EN;
            par_typ_lat <= PAR_TYP;
            bit_cnt_r   <= '0;
            par_bad_r   <= 1'b0;
         end
         if (bit_done) begin
            case (state_r)
               DATA: begin
                  shift_r   <= {sampled_bit, shift_r[DATA_WIDTH-1:1]};
                  bit_cnt_r <= (bit_cnt_r == BIT_CNT_W'(DATA_WIDTH - 1)) ? '0 : bit_cnt_r + BIT_CNT_W'(1);
               end
               PARITY: par_bad_r <= sampled_bit != (par_typ_lat ? ~^shift_r : ^shift_r);
               STOP: begin
                  data_valid <= frame_ok;
                  par_err    <= par_bad_r;
                  stp_err    <= !sampled_bit;
                  if (frame_ok) P_DATA <= shift_r;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, corner-case sequences and random frames
// checked against a frame-level model (parity by bit count, latency by bit-period arithmetic).
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       RX_IN;
   logic [5:0] prescale;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [7:0] P_DATA;
   logic       data_valid;
   logic       par_err;
   logic       stp_err;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   uart_rx dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .RX_IN     (RX_IN),
      .prescale  (prescale),
      .PAR_EN    (PAR_EN),
      .PAR_TYP   (PAR_TYP),
      .P_DATA    (P_DATA),
      .data_valid(data_valid),
      .par_err   (par_err),
      .stp_err   (stp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic       v;
      logic       pe;
      logic       se;
      logic [7:0] d;
   } ev_t;

   ev_t evq[$];

   // Every cycle with any strobe high is logged; a correct frame produces exactly one entry.
   always @(negedge clk)
      if (data_valid || par_err || stp_err)
         evq.push_back('{cyc, data_valid, par_err, stp_err, P_DATA});

   typedef struct {
      logic [5:0] p;
      logic       pe;
      logic       pt;
      logic [7:0] d;
      logic       pbit;
      logic       sbit;
      logic       xv;
      logic       xpe;
      logic       xse;
      logic [7:0] xd;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int eff_p(input logic [5:0] p);
      return (p == 6'd8 || p == 6'd16 || p == 6'd32) ? int'(p) : 8;
   endfunction

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Caller sits 1 time unit after a rising edge; the next edge is the detection edge.
   task automatic send_frame(input logic [5:0] p_raw, input logic pe, input logic pt,
                             input logic [7:0] d, input logic pbit, input logic sbit,
                             output int det);
      int p;
      p        = eff_p(p_raw);
      prescale = p_raw;
      PAR_EN   = pe;
      PAR_TYP  = pt;
      RX_IN    = 1'b0;
      det      = cyc + 1;
      hold(1);
      prescale = 6'($urandom);
      PAR_EN   = 1'($urandom);
      PAR_TYP  = 1'($urandom);
      hold(p - 1);
      for (int i = 0; i < 8; i++) begin
         RX_IN = d[i];
         hold(p);
      end
      if (pe) begin
         RX_IN = pbit;
         hold(p);
      end
      RX_IN = sbit;
      hold(p);
      RX_IN = 1'b1;
   endtask

   task automatic check_event(input string tag, input int det, input int lat,
                              input logic xv, input logic xpe, input logic xse,
                              input logic [7:0] xd);
      ev_t e;
      check({tag, "_strobe_seen"}, 32'(evq.size() != 0), 32'd1);
      if (evq.size() != 0) begin
         e = evq.pop_front();
         check({tag, "_latency"},    32'(e.cyc - det), 32'(lat));
         check({tag, "_data_valid"}, 32'(e.v),  32'(xv));
         check({tag, "_par_err"},    32'(e.pe), 32'(xpe));
         check({tag, "_stp_err"},    32'(e.se), 32'(xse));
         check({tag, "_p_data"},     32'(e.d),  32'(xd));
      end
   endtask

   vec_t       tbl[8];
   logic [5:0] pvals[6];
   logic [7:0] model_pdata;
   int         det, det2;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{6'd8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
      tbl[1] = '{6'd16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C};
      tbl[2] = '{6'd16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C};
      tbl[3] = '{6'd32, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C};
      tbl[4] = '{6'd5,  1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h96};
      tbl[5] = '{6'd16, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF};
      tbl[6] = '{6'd8,  1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF};
      tbl[7] = '{6'd32, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80};
      pvals  = '{6'd8, 6'd16, 6'd32, 6'd8, 6'd0, 6'd40};

      rst_n    = 1'b0;
      RX_IN    = 1'b1;
      prescale = 6'd8;
      PAR_EN   = 1'b0;
      PAR_TYP  = 1'b0;
      #1;
      check("reset_p_data",     32'(P_DATA),     32'd0);
      check("reset_data_valid", 32'(data_valid), 32'd0);
      check("reset_par_err",    32'(par_err),    32'd0);
      check("reset_stp_err",    32'(stp_err),    32'd0);
      #22 rst_n = 1'b1;
      @(posedge clk);
      #1;
      hold(2);

      for (int i = 0; i < 8; i++) begin
         send_frame(tbl[i].p, tbl[i].pe, tbl[i].pt, tbl[i].d, tbl[i].pbit, tbl[i].sbit, det);
         hold(3);
         check_event($sformatf("vec%0d", i), det, eff_p(tbl[i].p) * (10 + int'(tbl[i].pe)) - 1,
                     tbl[i].xv, tbl[i].xpe, tbl[i].xse, tbl[i].xd);
         check($sformatf("vec%0d_extra_strobes", i), 32'(evq.size()), 32'd0);
      end

      // Two-clock glitch on the line must be rejected at the end of the start bit.
      prescale = 6'd8;
      PAR_EN   = 1'b0;
      RX_IN    = 1'b0;
      hold(2);
      RX_IN = 1'b1;
      hold(20);
      check("glitch_no_strobe", 32'(evq.size()), 32'd0);
      send_frame(6'd8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, det);
      hold(3);
      check_event("after_glitch", det, 79, 1'b1, 1'b0, 1'b0, 8'h5A);

      // Back-to-back frames with no idle gap.
      send_frame(6'd16, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, det);
      send_frame(6'd16, 1'b0, 1'b0, 8'hEE, 1'b0, 1'b1, det2);
      hold(3);
      check("b2b_start_spacing", 32'(det2 - det), 32'd160);
      check_event("b2b_first",  det,  159, 1'b1, 1'b0, 1'b0, 8'h11);
      check_event("b2b_second", det2, 159, 1'b1, 1'b0, 1'b0, 8'hEE);
      check("b2b_extra_strobes", 32'(evq.size()), 32'd0);

      model_pdata = 8'hEE;
      for (int i = 0; i < 20; i++) begin
         logic [5:0] p_raw;
         logic       pe, pt, pbit, sbit, par_ok, xv;
         logic [7:0] d;
         p_raw  = pvals[$urandom_range(0, 5)];
         pe     = 1'($urandom);
         pt     = 1'($urandom);
         d      = 8'($urandom);
         pbit   = 1'($urandom);
         sbit   = ($urandom_range(0, 7) != 0);
         par_ok = !pe || (($countones({d, pbit}) % 2) == (pt ? 1 : 0));
         xv     = par_ok && sbit;
         if (xv) model_pdata = d;
         send_frame(p_raw, pe, pt, d, pbit, sbit, det);
         hold(3);
         check_event($sformatf("rand%0d", i), det, eff_p(p_raw) * (10 + int'(pe)) - 1,
                     xv, !par_ok, !sbit, model_pdata);
         check($sformatf("rand%0d_extra_strobes", i), 32'(evq.size()), 32'd0);
      end

      // Reset asserted mid-DATA: outputs clear immediately and the frame is dropped.
      prescale = 6'd16;
      PAR_EN   = 1'b0;
      RX_IN    = 1'b0;
      hold(16);
      RX_IN = 1'b1;
      hold(16);
      RX_IN = 1'b0;
      hold(16);
      #3 rst_n = 1'b0;
      #1;
      check("midreset_p_data",     32'(P_DATA),     32'd0);
      check("midreset_data_valid", 32'(data_valid), 32'd0);
      check("midreset_par_err",    32'(par_err),    32'd0);
      check("midreset_stp_err",    32'(stp_err),    32'd0);
      RX_IN = 1'b1;
      hold(3);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      hold(40);
      check("midreset_no_strobe", 32'(evq.size()), 32'd0);
      send_frame(6'd16, 1'b0, 1'b0, 8'h77, 1'b0, 1'b1, det);
      hold(3);
      check_event("after_reset", det, 159, 1'b1, 1'b0, 1'b0, 8'h77);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
